// File: rtl/dsp_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_seq_pkg
// Description : Shared types and default widths for the dot-product
//               sequencer that drives an external multiply-accumulate slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_mac_seq_pkg;

    localparam int c_DEF_WIDTH_OP1 = 18;
    localparam int c_DEF_WIDTH_OP2 = 25;
    localparam int c_DEF_WIDTH_OUT = 48;
    localparam int c_DEF_LEN_W     = 8;
    localparam int c_DEF_DSP_LAT   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } dsp_mac_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_seq
// Description : Streams LEN signed operand pairs into an external DSP MAC
//               slice, drains its pipeline and returns the accumulated sum
//               on a valid/ready result port.
//               Optional macro DSP_MAC_SEQ_BIAS_EN adds a BIAS preload input.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_seq
    import dsp_mac_seq_pkg::*;
#(
    parameter int WIDTH_OP1 = c_DEF_WIDTH_OP1,
    parameter int WIDTH_OP2 = c_DEF_WIDTH_OP2,
    parameter int WIDTH_OUT = c_DEF_WIDTH_OUT,
    parameter int LEN_W     = c_DEF_LEN_W,
    parameter int DSP_LAT   = c_DEF_DSP_LAT
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [LEN_W-1:0]     LEN,
`ifdef DSP_MAC_SEQ_BIAS_EN
    input  logic [WIDTH_OUT-1:0] BIAS,
`endif
    output logic                 BUSY,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH_OP1-1:0] IN_OP1,
    input  logic [WIDTH_OP2-1:0] IN_OP2,
    output logic                 DSP_EN,
    output logic                 DSP_ACC_EN,
    output logic                 DSP_ACC_IN_EN,
    output logic [WIDTH_OP1-1:0] DSP_OP1,
    output logic [WIDTH_OP2-1:0] DSP_OP2,
    output logic [WIDTH_OUT-1:0] DSP_ACC,
    input  logic [WIDTH_OUT-1:0] DSP_OUT,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [WIDTH_OUT-1:0] RES_DATA
);

    // Drain counter must hold DSP_LAT itself, and at least one bit.
    localparam int c_DRAIN_W = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);

    dsp_mac_seq_state_t     r_state;
    dsp_mac_seq_state_t     w_state_nxt;
    logic [LEN_W-1:0]       r_rem;
    logic [c_DRAIN_W-1:0]   r_drain;
    logic                   r_issued;
    logic [WIDTH_OUT-1:0]   r_res_data;
    logic                   w_hs;
    logic                   w_last;

`ifdef DSP_MAC_SEQ_BIAS_EN
    logic [WIDTH_OUT-1:0]   r_bias;
`endif

    // An operand beat is consumed only while feeding; READY is 1 throughout FEED.
    assign w_hs   = (r_state == S_FEED) && IN_VALID;
    assign w_last = w_hs && (r_rem == LEN_W'(1));

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; START is only honoured while IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = (LEN == '0) ? S_DONE : S_FEED;
            S_FEED:  if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain == '0) w_state_nxt = S_DONE;
            S_DONE:  if (RES_READY) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat/drain counters, first-beat flag and result capture.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_rem      <= '0;
            r_drain    <= '0;
            r_issued   <= 1'b0;
            r_res_data <= '0;
`ifdef DSP_MAC_SEQ_BIAS_EN
            r_bias     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_rem    <= LEN;
                        r_issued <= 1'b0;
`ifdef DSP_MAC_SEQ_BIAS_EN
                        r_bias   <= BIAS;
                        if (LEN == '0) r_res_data <= BIAS;
`else
                        if (LEN == '0) r_res_data <= '0;
`endif
                    end
                end
                S_FEED: begin
                    if (w_hs) begin
                        r_rem    <= r_rem - LEN_W'(1);
                        r_issued <= 1'b1;
                        if (w_last) r_drain <= c_DRAIN_W'(DSP_LAT);
                    end
                end
                S_DRAIN: begin
                    // The last beat reaches DSP_OUT exactly when the counter has run out.
                    if (r_drain != '0) begin
                        r_drain <= r_drain - c_DRAIN_W'(1);
                    end else begin
                        r_res_data <= DSP_OUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; bubbles carry zero operands and the first real beat
    // restarts the accumulator so earlier bubbles never leak into the sum.
    always_comb begin
        BUSY          = (r_state != S_IDLE);
        IN_READY      = 1'b0;
        DSP_EN        = 1'b0;
        DSP_ACC_EN    = 1'b0;
        DSP_ACC_IN_EN = 1'b0;
        DSP_OP1       = '0;
        DSP_OP2       = '0;
        DSP_ACC       = '0;
        RES_VALID     = 1'b0;
        case (r_state)
            S_FEED: begin
                IN_READY   = 1'b1;
                DSP_EN     = 1'b1;
                DSP_ACC_EN = r_issued;
                if (w_hs) begin
                    DSP_OP1 = IN_OP1;
                    DSP_OP2 = IN_OP2;
`ifdef DSP_MAC_SEQ_BIAS_EN
                    if (!r_issued) begin
                        DSP_ACC_IN_EN = 1'b1;
                        DSP_ACC       = r_bias;
                    end
`endif
                end
            end
            S_DRAIN: begin
                DSP_EN     = 1'b1;
                DSP_ACC_EN = 1'b1;
            end
            S_DONE: begin
                RES_VALID = 1'b1;
            end
            default: ;
        endcase
    end

    assign RES_DATA = r_res_data;

endmodule
`default_nettype wire

// File: doc/dsp_mac_seq.md
# dsp_mac_seq

Sequencer that drives one `DSP` multiply-accumulate slice to compute signed dot products of length `LEN`. It accepts a START command, streams operand pairs from a valid/ready source into the slice, and drains the slice pipeline. It then presents the accumulated result on a valid/ready result port. It sits between the operand buffer logic and a `DSP` instance, which the parent instantiates.

## Interface
- `WIDTH_OP1`, 18, OP1 width (signed)
- `WIDTH_OP2`, 25, OP2 width (signed)
- `WIDTH_OUT`, 48, accumulator/result width (signed)
- `LEN_W`, 8, width of LEN
- `DSP_LAT`, 3, DSP latency: a beat registered at edge k is visible on DSP_OUT after edge k+DSP_LAT

- `CLK` in 1: single clock
- `RSTN` in 1: synchronous, active-low reset
- `START` in 1: command strobe, sampled only in IDLE
- `LEN` in LEN_W: number of products, sampled with START
- `BUSY` out 1: high in every state except IDLE
- `IN_VALID` in 1, `IN_READY` out 1, `IN_OP1` in WIDTH_OP1, `IN_OP2` in WIDTH_OP2: operand stream
- `DSP_EN` out 1, `DSP_ACC_EN` out 1, `DSP_ACC_IN_EN` out 1: DSP control
- `DSP_OP1` out WIDTH_OP1, `DSP_OP2` out WIDTH_OP2: DSP operands
- `DSP_ACC` out WIDTH_OUT: DSP preload value
- `DSP_OUT` in WIDTH_OUT: DSP accumulator output
- `RES_VALID` out 1, `RES_READY` in 1, `RES_DATA` out WIDTH_OUT: result stream

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - START=1 with LEN≠0 → FEED; latch LEN into the remaining counter and clear the issued flag.
  - START=1 with LEN=0 → DONE with RES_DATA=0.
- FEED:
  - IN_READY=1 and DSP_EN=1 every cycle.
  - Handshake (IN_VALID&IN_READY): DSP_OP1/DSP_OP2 = IN_OP1/IN_OP2 combinationally; remaining counter decrements.
  - No handshake: DSP_OP1/DSP_OP2 = 0 (bubble).
  - DSP_ACC_EN = 0 until the first real beat has been issued (that beat included), 1 afterwards. Bubbles therefore never corrupt the sum.
  - Last beat accepted → DRAIN; drain counter loaded with DSP_LAT.
- DRAIN:
  - DSP_EN=1, operands 0, DSP_ACC_EN=1, IN_READY=0.
  - Counter reaches 0 → DONE; DSP_OUT captured into RES_DATA at that edge.
- DONE:
  - RES_VALID=1 and RES_DATA held until RES_READY=1 → IDLE.
- Outside FEED/DRAIN: DSP_EN=0, DSP_ACC_EN=0, operands 0.
- Arithmetic: signed two's complement. The result wraps modulo 2^WIDTH_OUT. No saturation and no overflow flag.
- START outside IDLE is ignored, including in the same cycle as a DONE→IDLE transition.
- LEN is ignored except when sampled with START.

## Timing
- Reset (RSTN=0 at an edge):
  - State → IDLE.
  - Zero: BUSY, IN_READY, DSP_EN, DSP_ACC_EN, DSP_ACC_IN_EN, DSP_OP1/2, DSP_ACC, RES_VALID, RES_DATA.
  - Beats in flight are discarded.
- Latency: START at edge e0 with IN_VALID continuously high.
  - Beats accepted at edges e1..eN.
  - RES_VALID rises after edge e0+N+DSP_LAT+1.
- Each IN_VALID gap adds exactly one cycle.
- LEN=0: RES_VALID rises after e0+1.
- Back-to-back throughput is one command per N+DSP_LAT+3 cycles (RES_READY held high).

## Configuration
- `DSP_MAC_SEQ_BIAS_EN` defined:
  - Adds input `BIAS` [WIDTH_OUT], sampled with START.
  - On the first real beat: DSP_ACC_IN_EN=1 and DSP_ACC=latched BIAS, so the result is BIAS + Σ products.
  - LEN=0 returns BIAS.
- Not defined:
  - No BIAS port.
  - DSP_ACC_IN_EN and DSP_ACC are tied to 0.

## Structure
- Package `dsp_mac_seq_pkg` holds:
  - the state enum `dsp_mac_seq_state_t`;
  - default width constants (18/25/48).
- Single flat module; no sub-module. The DSP instance belongs to the parent.

## Test plan
- LEN=3; operands (2,3), (−4,5), (7,−1); IN_VALID always high → RES_DATA=−21. RES_VALID rises 7 cycles after the START edge (DSP_LAT=3).
- Same vectors with IN_VALID low for 2 cycles between beats 1 and 2 → RES_DATA=−21, latency 9 cycles.
- LEN=4, all operands (−131072, −16777216) → RES_DATA=8796093022208. LEN=0 → RES_DATA=0 one cycle after START.
- RES_READY held low for 5 cycles → RES_VALID/RES_DATA stable. A START pulse during that time is ignored and BUSY stays 1.
- RSTN low for one edge mid-FEED after 2 of 5 beats → all outputs 0 next cycle. A new LEN=1 (3,3) command → 9.
- With `DSP_MAC_SEQ_BIAS_EN`, BIAS=100 plus the first vectors → RES_DATA=79.
